pmod_audio_mc: RTL and testbench
================================

# pmod_audio_mc

Multi-channel, parametrised audio DAC driver for PMOD-attached RC-filtered outputs. It is the successor to the single-channel fixed 9-bit PWM driver. It accepts frames of per-channel samples through a valid/ready handshake and buffers one frame ahead. Each channel is converted to a 1-bit stream by either fixed-period PWM or first-order sigma-delta. It sits between the APU sample mixer and the PMOD pins.

## Interface
- CHANNELS, 2: number of independent output channels.
- SAMPLE_W, 16: bits per channel sample.
- PWM_BITS, 9: frame period is 2^PWM_BITS clocks; PWM duty resolution. Must be ≤ SAMPLE_W.
- SIGNED_IN, 1: 1 = two's-complement input, 0 = offset-binary input.
- SD_MODE, 0: 0 = PWM, 1 = first-order sigma-delta.

- clk  in  1  system clock (21.477 MHz nominal).
- rst_n  in  1  asynchronous, active-low reset.
- sample  in  CHANNELS*SAMPLE_W  frame data; channel k occupies bits [k*SAMPLE_W +: SAMPLE_W].
- sample_valid  in  1  frame on `sample` is valid.
- sample_ready  out  1  pending buffer is empty; a frame can be accepted.
- mute  in  1  force silence at the next frame boundary.
- output_pmod  out  CHANNELS  1-bit DAC streams, registered.
- frame_strobe  out  1  one-cycle pulse on every frame boundary.
- underrun  out  1  one-cycle pulse on a boundary where no pending frame existed.

## Operation
- Frame counter `cnt` has PWM_BITS bits and increments every clock, wrapping 2^PWM_BITS-1 → 0. A boundary is any cycle with `cnt == 0`.
- Conversion: if SIGNED_IN, u = sample with MSB inverted; otherwise u = sample.
- Buffering: one pending register per frame plus `pend_valid`. `sample_ready = !pend_valid`. A transfer occurs when `sample_valid && sample_ready`; it stores u for all channels and sets `pend_valid`.
- At a boundary:
  - If `pend_valid`, copy pending into `active` and clear `pend_valid`.
  - Otherwise keep `active`, so the last frame repeats, and pulse `underrun`.
- Simultaneous transfer and boundary with `pend_valid == 0`: the boundary sees an empty buffer (underrun pulses). The new frame lands in pending and plays from the following boundary.
- Mute: `mute` is sampled at each boundary. While the sampled mute is 1, the effective code for every channel is midscale (1 << (SAMPLE_W-1)). `active` and the buffer keep operating normally.
- PWM mode: code = top PWM_BITS bits of the effective u. The channel drives high while `cnt < code`.
  - code 0 → always low.
  - code 2^PWM_BITS-1 → high for all but one cycle per frame.
- Sigma-delta mode: a per-channel SAMPLE_W-bit accumulator computes {carry, acc} <= acc + u_eff every clock. The output is the carry. Frame and latching rules are the same as in PWM mode.
- Reset values:
  - `cnt`, accumulators, `output_pmod`, `frame_strobe`, `underrun`, `pend_valid` = 0, so `sample_ready` = 1.
  - `active` = midscale on every channel.
  - Sampled mute = 0.
- Reset asserted mid-frame: everything returns to reset values immediately and any pending frame is discarded.

## Timing
- `output_pmod`, `frame_strobe` and `underrun` are registered. The output in cycle t+1 reflects `cnt` and `active` from cycle t.
- The first clock after reset release is a boundary (`cnt == 0`). `frame_strobe` is high in the following cycle.
- Latency from transfer to audible output:
  - Transfer at cnt = c with the buffer empty: the frame becomes active at the next boundary, after 2^PWM_BITS − c clocks. Output follows one cycle later.
  - Transfer exactly at cnt = 0: the frame waits a full period.
- Throughput: at most one frame per period. `sample_ready` returns high in the cycle after the boundary that consumes the pending frame.

## Test plan
- Reset, no input (defaults): after `rst_n` rises, each channel is high exactly 256 of every 512 cycles. `underrun` pulses once per frame, and `frame_strobe` has a period of 512.
- SIGNED_IN=1, frame ch0=0x7FFF, ch1=0x8000: in the next frame, ch0 is high 511 of 512 cycles and ch1 is constantly low. Apply the same values with SIGNED_IN=0: ch0 = 255 high cycles, ch1 = 256 high cycles.
- Back-to-back frames A and B with `sample_valid` held high:
  - A is accepted immediately, `sample_ready` goes low, and B stalls.
  - B is accepted the cycle after A's boundary.
  - A plays for one frame, then B plays, with no underrun pulse.
- Transfer coinciding with `cnt == 0` on an empty buffer: `underrun` pulses, the old frame repeats, and the new frame plays from the next boundary.
- SD_MODE=1, signed 0xC000 (u = 0x4000): the output is high on every 4th clock, exactly 128 of 512 cycles per frame. Asserting `mute` gives 1-in-2 output from the next boundary.
- Assert `rst_n` low at cnt = 100 with a pending frame: outputs are immediately 0 and `sample_ready` = 1. After release, midscale output resumes and the discarded frame never appears.

Source files
------------

// File: rtl/pmod_audio_mc.sv
// pmod_audio_mc: multi-channel audio DAC driver for RC-filtered PMOD outputs.
// Frames of per-channel samples are accepted one frame ahead and converted
// to 1-bit streams by fixed-period PWM or first-order sigma-delta.
module pmod_audio_mc #(
    parameter int CHANNELS  = 2,
    parameter int SAMPLE_W  = 16,
    parameter int PWM_BITS  = 9,
    parameter int SIGNED_IN = 1,
    parameter int SD_MODE   = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS*SAMPLE_W-1:0] sample,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    input  logic                         mute,
    output logic [CHANNELS-1:0]          output_pmod,
    output logic                         frame_strobe,
    output logic                         underrun
);

    // Midscale code: the silent level for an unsigned (offset-binary) sample.
    localparam logic [SAMPLE_W-1:0] MID    = {1'b1, {(SAMPLE_W-1){1'b0}}};
    // Two's-complement input becomes offset-binary by flipping the MSB.
    localparam logic [SAMPLE_W-1:0] IN_XOR = (SIGNED_IN != 0) ? MID : '0;

    // Handshake: a frame transfers on any cycle where sample_valid and
    // sample_ready are both high; sample_ready is high exactly when the
    // pending buffer is empty and does not depend on sample_valid.

    logic [PWM_BITS-1:0]   cnt;
    logic                  boundary;
    logic                  pend_valid;
    logic                  xfer;
    logic                  mute_s;
    logic                  eff_mute;
    logic                  load_pend;

    logic [SAMPLE_W-1:0]   in_u      [CHANNELS];
    logic [SAMPLE_W-1:0]   pend_u    [CHANNELS];
    logic [SAMPLE_W-1:0]   active_u  [CHANNELS];
    logic [SAMPLE_W-1:0]   frame_u   [CHANNELS];
    logic [SAMPLE_W-1:0]   u_eff     [CHANNELS];
    logic [PWM_BITS-1:0]   code      [CHANNELS];
    logic [SAMPLE_W-1:0]   acc       [CHANNELS];
    logic [SAMPLE_W:0]     sd_sum    [CHANNELS];
    logic [CHANNELS-1:0]   bit_next;

    assign boundary     = (cnt == '0);
    assign sample_ready = !pend_valid;
    assign xfer         = sample_valid && !pend_valid;
    assign load_pend    = boundary && pend_valid;

    // Mute and the active frame take effect on the boundary cycle itself, so
    // the output frame that starts one cycle later is entirely the new one.
    assign eff_mute = boundary ? mute : mute_s;

    // Per-channel input conversion, effective code selection and modulators.
    always_comb begin
        bit_next = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            in_u[k]    = sample[k*SAMPLE_W +: SAMPLE_W] ^ IN_XOR;
            frame_u[k] = load_pend ? pend_u[k] : active_u[k];
            u_eff[k]   = eff_mute ? MID : frame_u[k];
            code[k]    = u_eff[k][SAMPLE_W-1 -: PWM_BITS];
            sd_sum[k]  = {1'b0, acc[k]} + {1'b0, u_eff[k]};
            if (SD_MODE != 0) begin
                bit_next[k] = sd_sum[k][SAMPLE_W];
            end else begin
                bit_next[k] = (cnt < code[k]);
            end
        end
    end

    // Free-running frame counter; wraps every 2^PWM_BITS clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // One-deep pending buffer; consumed at each boundary, refilled by xfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                pend_u[k] <= '0;
            end
        end else begin
            if (load_pend) begin
                pend_valid <= 1'b0;
            end else if (xfer) begin
                pend_valid <= 1'b1;
            end
            if (xfer) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    pend_u[k] <= in_u[k];
                end
            end
        end
    end

    // Active frame and sampled mute change only at a boundary; an empty
    // buffer at the boundary leaves the previous frame playing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mute_s <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                active_u[k] <= MID;
            end
        end else if (boundary) begin
            mute_s <= mute;
            for (int k = 0; k < CHANNELS; k++) begin
                active_u[k] <= frame_u[k];
            end
        end
    end

    // Sigma-delta accumulators run every clock; the carry is the output bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CHANNELS; k++) begin
                acc[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                acc[k] <= sd_sum[k][SAMPLE_W-1:0];
            end
        end
    end

    // Registered pin outputs and frame status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_pmod  <= '0;
            frame_strobe <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            output_pmod  <= bit_next;
            frame_strobe <= boundary;
            underrun     <= boundary && !pend_valid;
        end
    end

endmodule

// File: tb/tb_pmod_audio_mc.sv
// Bench for pmod_audio_mc: three instances (signed PWM, unsigned PWM,
// signed sigma-delta) share one stimulus stream and are checked every cycle
// against a frame-level model, plus hand-computed per-frame high counts.
module tb_pmod_audio_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] sample;
    logic        sample_valid;
    logic        mute;

    logic [1:0] op0, op1, op2;
    logic       rdy0, rdy1, rdy2;
    logic       fs0, fs1, fs2;
    logic       un0, un1, un2;

    int tests  = 0;
    int failed = 0;
    bit chk_en = 1'b0;

    // clock / reset
    always #5 clk = ~clk;

    pmod_audio_mc #(.SIGNED_IN(1), .SD_MODE(0)) dut_s_pwm (
        .clk(clk), .rst_n(rst_n), .sample(sample), .sample_valid(sample_valid),
        .sample_ready(rdy0), .mute(mute), .output_pmod(op0),
        .frame_strobe(fs0), .underrun(un0));

    pmod_audio_mc #(.SIGNED_IN(0), .SD_MODE(0)) dut_u_pwm (
        .clk(clk), .rst_n(rst_n), .sample(sample), .sample_valid(sample_valid),
        .sample_ready(rdy1), .mute(mute), .output_pmod(op1),
        .frame_strobe(fs1), .underrun(un1));

    pmod_audio_mc #(.SIGNED_IN(1), .SD_MODE(1)) dut_s_sd (
        .clk(clk), .rst_n(rst_n), .sample(sample), .sample_valid(sample_valid),
        .sample_ready(rdy2), .mute(mute), .output_pmod(op2),
        .frame_strobe(fs2), .underrun(un2));

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] pend_q[$];
    int          m_cnt;
    bit          m_mute;
    logic [15:0] m_act [3][2];
    int          m_acc [2];
    logic [1:0]  exp_out [3];
    bit          exp_fs, exp_un, exp_ready;

    // Instance 1 takes offset-binary input, the others two's complement.
    function automatic logic [15:0] to_u(input int inst, input logic [15:0] raw);
        return (inst == 1) ? raw : (raw ^ 16'h8000);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit          bnd, rdy_before;
        logic [31:0] fr;
        logic [15:0] u;
        int          s;
        if (!rst_n) begin
            pend_q.delete();
            m_cnt = 0;
            m_mute = 0;
            for (int i = 0; i < 3; i++) begin
                exp_out[i] = 2'b00;
                for (int c = 0; c < 2; c++) m_act[i][c] = 16'h8000;
            end
            m_acc[0] = 0;
            m_acc[1] = 0;
            exp_fs = 0;
            exp_un = 0;
            exp_ready = 1;
        end else begin
            bnd = (m_cnt == 0);
            rdy_before = (pend_q.size() == 0);
            exp_un = 0;
            if (bnd) begin
                if (!rdy_before) begin
                    fr = pend_q.pop_front();
                    for (int i = 0; i < 3; i++)
                        for (int c = 0; c < 2; c++)
                            m_act[i][c] = to_u(i, fr[c*16 +: 16]);
                end else begin
                    exp_un = 1;
                end
                m_mute = mute;
            end
            if (sample_valid && rdy_before) pend_q.push_back(sample);
            for (int i = 0; i < 3; i++) begin
                for (int c = 0; c < 2; c++) begin
                    u = m_mute ? 16'h8000 : m_act[i][c];
                    if (i == 2) begin
                        s = m_acc[c] + int'(u);
                        exp_out[i][c] = (s >= 65536);
                        m_acc[c] = s % 65536;
                    end else begin
                        exp_out[i][c] = (m_cnt < int'(u) / 128);
                    end
                end
            end
            exp_fs = bnd;
            m_cnt = (m_cnt + 1) % 512;
            exp_ready = (pend_q.size() == 0);
        end
    end

    // ---------------- scoreboard / window tracker ----------------
    int run_hi  [3][2];
    int last_hi [3][2];
    int run_un, last_un;
    int per;
    bit per_seen;

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_s_pwm", op0, exp_out[0]);
            check("out_u_pwm", op1, exp_out[1]);
            check("out_s_sd",  op2, exp_out[2]);
            check("strobe0", fs0, exp_fs);
            check("strobe1", fs1, exp_fs);
            check("strobe2", fs2, exp_fs);
            check("underrun0", un0, exp_un);
            check("underrun1", un1, exp_un);
            check("underrun2", un2, exp_un);
            check("ready0", rdy0, exp_ready);
            check("ready1", rdy1, exp_ready);
            check("ready2", rdy2, exp_ready);
        end
        if (!rst_n) begin
            per_seen = 0;
        end else if (fs0) begin
            if (per_seen) check("strobe_period", per, 512);
            per_seen = 1;
            per = 1;
        end else begin
            per++;
        end
        for (int c = 0; c < 2; c++) begin
            if (fs0) begin
                last_hi[0][c] = run_hi[0][c]; run_hi[0][c] = int'(op0[c]);
                last_hi[1][c] = run_hi[1][c]; run_hi[1][c] = int'(op1[c]);
                last_hi[2][c] = run_hi[2][c]; run_hi[2][c] = int'(op2[c]);
            end else begin
                run_hi[0][c] += int'(op0[c]);
                run_hi[1][c] += int'(op1[c]);
                run_hi[2][c] += int'(op2[c]);
            end
        end
        if (fs0) begin
            last_un = run_un;
            run_un = int'(un0);
        end else begin
            run_un += int'(un0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [15:0] ch0, input logic [15:0] ch1, input bit hold);
        bit r;
        int n;
        sample = {ch1, ch0};
        sample_valid = 1'b1;
        n = 0;
        do begin
            r = rdy0;
            @(posedge clk);
            #2;
            n++;
        end while (!r && n < 2000);
        check("send_accepted", int'(r), 1);
        if (!hold) sample_valid = 1'b0;
    endtask

    task automatic wait_strobe();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!fs0 && n < 600);
        check("strobe_seen", fs0, 1);
    endtask

    task automatic wait_strobes(input int k);
        for (int i = 0; i < k; i++) wait_strobe();
    endtask

    task automatic check_frame(input string name, input int inst,
                               input int hi0, input int hi1);
        check({name, "_ch0"}, last_hi[inst][0], hi0);
        check({name, "_ch1"}, last_hi[inst][1], hi1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0;
        sample = '0;
        sample_valid = 1'b0;
        mute = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        check("rst_out", int'({op0, op1, op2}), 0);
        check("rst_ready", rdy0, 1);
        check("rst_strobe", fs0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // defaults: midscale everywhere, one underrun per frame
        wait_strobes(2);
        check_frame("dflt_s_pwm", 0, 256, 256);
        check_frame("dflt_u_pwm", 1, 256, 256);
        check_frame("dflt_s_sd",  2, 256, 256);
        check("dflt_underruns", last_un, 1);

        // full-scale / minimum codes, signed vs unsigned interpretation
        send(16'h7FFF, 16'h8000, 0);
        wait_strobes(3);
        check_frame("ext_s_pwm", 0, 511, 0);
        check_frame("ext_u_pwm", 1, 255, 256);

        // back-to-back A then B with valid held high
        send(16'h4000, 16'hC000, 1);
        check("a_ready_low", rdy0, 0);
        send(16'h1000, 16'hF000, 0);
        wait_strobe();
        check_frame("frame_a", 0, 384, 128);
        check("frame_a_underrun", last_un, 0);
        wait_strobe();
        check_frame("frame_b", 0, 288, 224);
        check("frame_b_underrun", last_un, 0);

        // transfer exactly on the boundary with an empty buffer
        repeat (511) @(posedge clk);
        #2;
        sample = {16'hE000, 16'h2000};
        sample_valid = 1'b1;
        @(posedge clk);
        #2;
        sample_valid = 1'b0;
        check("bnd_underrun", un0, 1);
        check("bnd_ready_low", rdy0, 0);
        wait_strobes(2);
        check_frame("bnd_repeat", 0, 288, 224);
        check("bnd_repeat_underrun", last_un, 1);
        wait_strobe();
        check_frame("bnd_new", 0, 320, 192);

        // sigma-delta quarter scale, then mute from the next boundary
        send(16'hC000, 16'hC000, 0);
        wait_strobes(3);
        check_frame("sd_quarter", 2, 128, 128);
        check_frame("pwm_quarter", 0, 128, 128);
        mute = 1'b1;
        wait_strobes(2);
        check_frame("sd_muted", 2, 256, 256);
        check_frame("pwm_muted", 0, 256, 256);
        check_frame("upwm_muted", 1, 256, 256);
        mute = 1'b0;

        // reset at cnt = 100 with a frame pending
        send(16'h7FFF, 16'h7FFF, 0);
        repeat (98) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out", int'({op0, op1, op2}), 0);
        check("midrst_ready", rdy0, 1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_strobes(2);
        check_frame("post_rst_s_pwm", 0, 256, 256);
        check_frame("post_rst_s_sd",  2, 256, 256);
        wait_strobe();
        check_frame("post_rst_again", 0, 256, 256);
        check("post_rst_underrun", last_un, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "timeout");
    end

endmodule
